// File: rtl/pwm_duty_gen.sv
// pwm_duty_gen
//   Turns the free-running 6-bit count of an upstream counter into a PWM
//   output. The duty is double-buffered: a new value is accepted over a
//   valid/ready handshake into a pending slot and only becomes active at the
//   next period boundary (a backwards step of count). The block also pulses
//   on each period wrap, counts completed periods (saturating) and flags a
//   counter that has stopped moving.
//
// Ports
//   clock       in   system clock, rising edge
//   clr         in   synchronous active-high reset
//   count[5:0]  in   counter value from the upstream counter
//   duty_in     in   requested duty, output high for counts 0..duty_in-1
//   duty_valid  in   duty_in valid this cycle
//   duty_ready  out  a new duty can be accepted (no duty pending)
//   pwm_out     out  registered PWM output, 1 clock behind count
//   wrap        out  one-cycle pulse, period boundary seen
//   period_cnt  out  completed periods, saturating
//   stalled     out  count unchanged for STALL_LIMIT clocks
//
// Handshake: a duty transfer happens on a rising edge where
//   duty_valid & duty_ready. duty_valid while duty_ready is low is dropped,
//   not queued. duty_ready depends only on registered state.

module pwm_duty_gen #(
  parameter int PERIOD_W    = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                clock,
  input  logic                clr,
  input  logic [5:0]          count,
  input  logic [5:0]          duty_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                pwm_out,
  output logic                wrap,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic                stalled
);

  localparam logic [15:0]         STALL_MAX = 16'(STALL_LIMIT);
  localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;

  logic [5:0]  count_q;
  logic [5:0]  active_duty;
  logic [5:0]  pending_duty;
  logic        pending;
  logic [15:0] stall_cnt;

  logic        wrap_det;
  logic        xfer;
  logic [5:0]  duty_eff;
  logic [15:0] stall_next;

  assign duty_ready = ~pending;

  always_comb begin
    // Any backwards step counts as a period boundary, not only 63->0.
    wrap_det = (count < count_q);
    xfer     = duty_valid & ~pending;

    // Duty that applies from this edge on; it only moves on a wrap, so the
    // duty never changes in the middle of a period. A transfer landing on
    // the wrap cycle itself is used immediately.
    duty_eff = active_duty;
    if (wrap_det) begin
      if (pending) begin
        duty_eff = pending_duty;
      end else if (xfer) begin
        duty_eff = duty_in;
      end
    end

    if (count != count_q) begin
      stall_next = '0;
    end else if (stall_cnt == STALL_MAX) begin
      stall_next = stall_cnt;
    end else begin
      stall_next = stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      count_q      <= '0;
      active_duty  <= '0;
      pending_duty <= '0;
      pending      <= 1'b0;
      stall_cnt    <= '0;
      pwm_out      <= 1'b0;
      wrap         <= 1'b0;
      period_cnt   <= '0;
      stalled      <= 1'b0;
    end else begin
      count_q     <= count;
      active_duty <= duty_eff;

      if (wrap_det) begin
        pending <= 1'b0;
      end else if (xfer) begin
        pending_duty <= duty_in;
        pending      <= 1'b1;
      end

      pwm_out <= (count < duty_eff);
      wrap    <= wrap_det;

      if (wrap_det && (period_cnt != PCNT_MAX)) begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end

      stall_cnt <= stall_next;
      stalled   <= (stall_next == STALL_MAX);
    end
  end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: hand-derived vector table, directed multi-cycle
// sequences and randomized traffic, all compared against a reference model.

module tb_pwm_duty_gen;

  localparam int PW    = 2;
  localparam int LIMIT = 8;
  localparam int PMAX  = (1 << PW) - 1;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          clr = 1'b1;
  logic [5:0]    count = '0;
  logic [5:0]    duty_in = '0;
  logic          duty_valid = 1'b0;
  logic          duty_ready;
  logic          pwm_out;
  logic          wrap;
  logic [PW-1:0] period_cnt;
  logic          stalled;

  always #5 clock = ~clock;

  pwm_duty_gen #(.PERIOD_W(PW), .STALL_LIMIT(LIMIT)) dut (
    .clock      (clock),
    .clr        (clr),
    .count      (count),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap       (wrap),
    .period_cnt (period_cnt),
    .stalled    (stalled)
  );

  // ---------------- reference model ----------------
  // Plain-integer view of the rules: a queue holds at most one pending duty.
  int         m_prev, m_active, m_pcnt, m_run;
  logic [5:0] pend_q[$];
  int         e_pwm, e_wrap, e_stalled, e_ready;

  task automatic model_step(input int c, input int d, input int v, input int r);
    int wrapped, accept;
    if (r != 0) begin
      m_prev = 0; m_active = 0; m_pcnt = 0; m_run = 0;
      pend_q.delete();
      e_pwm = 0; e_wrap = 0; e_stalled = 0;
    end else begin
      wrapped = (c < m_prev) ? 1 : 0;
      accept  = (v != 0 && pend_q.size() == 0) ? 1 : 0;
      if (wrapped != 0) begin
        if (pend_q.size() > 0) m_active = int'(pend_q.pop_front());
        else if (accept != 0)  m_active = d;
      end else if (accept != 0) begin
        pend_q.push_back(6'(d));
      end
      e_pwm  = (c < m_active) ? 1 : 0;
      e_wrap = wrapped;
      if (wrapped != 0 && m_pcnt < PMAX) m_pcnt++;
      if (c == m_prev) m_run = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
      else             m_run = 0;
      e_stalled = (m_run == LIMIT) ? 1 : 0;
      m_prev = c;
    end
    e_ready = (pend_q.size() == 0) ? 1 : 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs away from the edge, advance one clock, sample #1 after it.
  task automatic apply(input int c, input int d, input int v, input int r);
    count      = 6'(c);
    duty_in    = 6'(d);
    duty_valid = (v != 0);
    clr        = (r != 0);
    model_step(c, d, v, r);
    @(posedge clock);
    #1;
    cyc++;
    chk("pwm_out",    int'(pwm_out),    e_pwm);
    chk("wrap",       int'(wrap),       e_wrap);
    chk("period_cnt", int'(period_cnt), m_pcnt);
    chk("stalled",    int'(stalled),    e_stalled);
    chk("duty_ready", int'(duty_ready), e_ready);
  endtask

  // Step count from..to one per clock, offering duty vd at count vc (vc<0: none).
  task automatic sweep(input int from, input int to, input int vc, input int vd,
                       output int highs, output int wraps);
    highs = 0;
    wraps = 0;
    for (int c = from; c <= to; c++) begin
      apply(c, (c == vc) ? vd : 0, (c == vc) ? 1 : 0, 0);
      highs += int'(pwm_out);
      wraps += int'(wrap);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       clr;
    logic [5:0] count;
    logic [5:0] duty;
    logic       valid;
    logic       pwm;
    logic       wrap;
    int         pcnt;
    logic       stalled;
    logic       ready;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int h, w;

    //         clr  cnt  duty vld  pwm  wrap pcnt stl  rdy
    vecs[0] = '{1'b1, 6'd37, 6'd9, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 6'd37, 6'd9, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 6'd1,  6'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 6'd2,  6'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 6'd1,  6'd0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 6'd3,  6'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 6'd2,  6'd0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 6'd2,  6'd0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1};

    #2;
    for (int i = 0; i < 10; i++) begin
      apply(int'(vecs[i].count), int'(vecs[i].duty), int'(vecs[i].valid), int'(vecs[i].clr));
      chk("vec_pwm",   int'(pwm_out),    int'(vecs[i].pwm));
      chk("vec_wrap",  int'(wrap),       int'(vecs[i].wrap));
      chk("vec_pcnt",  int'(period_cnt), vecs[i].pcnt);
      chk("vec_stall", int'(stalled),    int'(vecs[i].stalled));
      chk("vec_ready", int'(duty_ready), int'(vecs[i].ready));
    end

    // Steady PWM with duty 16 over three periods, then saturation.
    apply(0, 0, 0, 1);
    apply(0, 0, 0, 1);
    sweep(0, 63, 1, 16, h, w);
    for (int p = 0; p < 3; p++) begin
      sweep(0, 63, -1, 0, h, w);
      chk("steady_highs", h, 16);
      chk("steady_wraps", w, 1);
      chk("steady_pcnt", int'(period_cnt), p + 1);
    end
    for (int p = 0; p < 3; p++) sweep(0, 63, -1, 0, h, w);
    chk("pcnt_saturated", int'(period_cnt), PMAX);

    // Deferred update: request 40 mid-period, old duty holds until wrap.
    sweep(0, 29, -1, 0, h, w);
    apply(30, 40, 1, 0);
    chk("deferred_not_ready", int'(duty_ready), 0);
    sweep(31, 63, -1, 0, h, w);
    chk("deferred_old_duty", h, 0);
    apply(0, 0, 0, 0);
    chk("deferred_ready_back", int'(duty_ready), 1);
    sweep(1, 63, -1, 0, h, w);
    chk("deferred_new_highs", h + 1, 40);

    // Back-pressure: the second offer while pending is dropped.
    sweep(0, 9, -1, 0, h, w);
    apply(10, 20, 1, 0);
    apply(11, 50, 1, 0);
    sweep(12, 63, -1, 0, h, w);
    sweep(0, 63, -1, 0, h, w);
    chk("backpressure_highs", h, 20);

    // Transfer coinciding with the wrap: used for the period it starts.
    apply(0, 8, 1, 0);
    chk("coincident_ready", int'(duty_ready), 1);
    h = int'(pwm_out);
    begin
      int h2, w2;
      sweep(1, 63, -1, 0, h2, w2);
      chk("coincident_highs", h + h2, 8);
    end

    // Stall: hold count at 5.
    sweep(0, 5, -1, 0, h, w);
    for (int i = 1; i <= LIMIT; i++) begin
      apply(5, 0, 0, 0);
      chk("stall_no_wrap", int'(wrap), 0);
      if (i == LIMIT - 1) chk("stall_not_yet", int'(stalled), 0);
    end
    chk("stall_set", int'(stalled), 1);
    apply(5, 0, 0, 0);
    chk("stall_held", int'(stalled), 1);
    apply(6, 0, 0, 0);
    chk("stall_cleared", int'(stalled), 0);
    chk("stall_release_no_wrap", int'(wrap), 0);

    // Edge duties 0 and 63.
    sweep(7, 63, 10, 0, h, w);
    sweep(0, 63, 5, 63, h, w);
    chk("duty0_highs", h, 0);
    sweep(0, 62, -1, 0, h, w);
    chk("duty63_highs_0_62", h, 63);
    apply(63, 0, 0, 0);
    chk("duty63_low_at_63", int'(pwm_out), 0);

    // Mid-period reset with a duty pending.
    sweep(0, 19, -1, 0, h, w);
    apply(20, 30, 1, 0);
    chk("pending_before_clr", int'(duty_ready), 0);
    apply(21, 0, 0, 1);
    chk("clr_ready", int'(duty_ready), 1);
    chk("clr_pwm", int'(pwm_out), 0);
    sweep(0, 63, -1, 0, h, w);
    sweep(0, 63, -1, 0, h, w);
    chk("clr_dropped_pending", h, 0);

    // Randomized traffic against the model.
    begin
      int cur = 0;
      int hold = 0;
      for (int i = 0; i < 3000; i++) begin
        int r, sel;
        if (hold > 0) begin
          hold--;
        end else begin
          sel = int'($urandom_range(0, 19));
          if (sel < 12)      cur = (cur + 1) % 64;
          else if (sel < 15) cur = cur;
          else if (sel < 17) cur = int'($urandom_range(0, 63));
          else if (sel == 17) hold = int'($urandom_range(LIMIT - 2, LIMIT + 4));
          else               cur = (cur + 1) % 64;
        end
        r = ($urandom_range(0, 199) == 0) ? 1 : 0;
        apply(cur, int'($urandom_range(0, 63)), ($urandom_range(0, 9) < 3) ? 1 : 0, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_gen.md
Name: pwm_duty_gen

Overview:
- Downstream consumer of the 6-bit ripple-style up-counter's `count` bus in the DriveSim FPGA datapath.
- Converts the free-running 0..63 count into a PWM output whose duty comes from a double-buffered duty register loaded over a valid/ready handshake.
- Also flags period wrap, counts completed periods and detects a stalled counter.
- `count` is synchronous to `clock`; it may advance every clock or slower (counter fed by an enable/divided tick).

Parameters:
- PERIOD_W, 16, width of the completed-period counter `period_cnt`.
- STALL_LIMIT, 1024, consecutive clocks with unchanged `count` before `stalled` asserts; legal range 1..65535.

Ports:
- clock  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous active-high reset
- count  in  6  counter value from upstream counter
- duty_in  in  6  requested duty (high for counts 0..duty_in-1)
- duty_valid  in  1  duty_in is valid this cycle
- duty_ready  out  1  block can accept a new duty
- pwm_out  out  1  registered PWM output
- wrap  out  1  one-cycle pulse, period boundary seen
- period_cnt  out  PERIOD_W  completed periods, saturating
- stalled  out  1  count unchanged for STALL_LIMIT clocks

Behaviour:
- Reset (clr=1 at an edge): count_q=0, active_duty=0, pending_duty=0, pending=0, stall counter=0. Outputs: pwm_out=0, wrap=0, period_cnt=0, stalled=0, duty_ready=1. Reset takes priority over every other event; mid-operation reset discards any pending duty.
- Sampling: count_q <= count every edge.
- Wrap detection: wrap_det = (count < count_q), combinational from live `count` vs previous sample.
  - Covers 63->0 and any backwards jump.
  - First sample after reset never wraps, since count_q=0.
- Registered outputs: wrap <= wrap_det, so wrap asserts one cycle after the edge where the new `count` is presented.
- Handshake:
  - duty_ready = ~pending.
  - Transfer when duty_valid & duty_ready; duty_valid with ready=0 is ignored, not queued.
- Duty update:
  - Transfer, no wrap_det: pending_duty <= duty_in, pending <= 1.
  - wrap_det with pending=1: active_duty <= pending_duty, pending <= 0.
  - wrap_det in the same cycle as a transfer (pending was 0): active_duty <= duty_in directly, pending stays 0.
  - Otherwise active_duty holds. The duty never changes mid-period.
- PWM:
  - pwm_out <= (count < duty_eff), where duty_eff = the value active_duty takes at this edge (new value on wrap cycles).
  - Latency is 1 clock from `count`.
  - duty 0 gives a constant low; duty 63 gives high for 63 of 64 counts. 100% duty is not supported.
- Period counter: period_cnt increments on each wrap_det and saturates at 2^PERIOD_W-1, with no roll-over.
- Stall detection:
  - Stall counter increments while count == count_q, saturating at STALL_LIMIT.
  - It resets to 0 on any edge where count != count_q.
  - stalled = (stall counter == STALL_LIMIT), registered. It drops one cycle after `count` changes.
  - pwm_out keeps tracking `count` while stalled.
- No combinational path from inputs to outputs except duty_ready, which depends only on registered pending.

Test Plan:
- Reset: clr=1 for 2 clocks with arbitrary inputs -> pwm_out=0, wrap=0, period_cnt=0, stalled=0, duty_ready=1; then count=0 held one clock -> no wrap.
- Steady PWM: load duty 16, count stepping 0..63 every clock for 3 periods -> pwm_out high for exactly 16 consecutive clocks per period, lagging count by 1; wrap is a single pulse one clock after count=0; period_cnt steps 1,2,3.
- Deferred update: duty 16 active; at count=30 send duty_in=40 -> duty_ready low next cycle; old duty used until wrap; from count=0 pwm high for 40 clocks; duty_ready returns high after wrap.
- Back-pressure and coincident events: second duty_valid while pending -> ignored, original pending value applied. Transfer exactly on the wrap cycle -> new duty used for that period, duty_ready stays 1.
- Stall: STALL_LIMIT=8, hold count=5 -> stalled=1 after 8 unchanged clocks; count=6 -> stalled=0 one clock later; no wrap generated.
- Saturation and edge duties: PERIOD_W=2, run 6 periods -> period_cnt sticks at 3. duty 0 -> pwm_out never high; duty 63 -> low only during count=63. clr asserted mid-period with pending set -> pending cleared, pwm_out=0.
